// File: rtl/pc_call_stack_pkg.sv
// Shared types and default sizes for the program-counter / call-stack unit.
// The instruction decoder imports pc_op_t from here.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_INC  = 3'b000,
    PC_SKIP = 3'b001,
    PC_GOTO = 3'b010,
    PC_CALL = 3'b011,
    PC_RET  = 3'b100,
    PC_HOLD = 3'b101
  } pc_op_t;

  localparam int PC_W_DEF  = 13;
  localparam int TGT_W_DEF = 11;
  localparam int DEPTH_DEF = 8;

endpackage

// File: rtl/pc_call_stack_ret_stack.sv
// Circular return-address LIFO with occupancy tracking and sticky error flags.
// Push and pop are mutually exclusive; the caller gates both with the phase strobe.
module ret_stack #(
  parameter int W     = 13,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear_err,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH)-1:0]   sp,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int SP_W = $clog2(DEPTH);
  localparam int DP_W = SP_W + 1;
  localparam logic [SP_W-1:0] SP_ONE    = SP_W'(1);
  localparam logic [DP_W-1:0] DP_ONE    = DP_W'(1);
  localparam logic [DP_W-1:0] DEPTH_MAX = DP_W'(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp_dec;

  assign sp_dec = sp - SP_ONE;
  assign rdata  = mem[sp_dec];
  assign full   = (depth == DEPTH_MAX);
  assign empty  = (depth == '0);

  // RAM is deliberately not reset; a reset edge must still suppress the write.
  always_ff @(posedge clk) begin
    if (reset && push) mem[sp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp        <= '0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        sp <= sp + SP_ONE;
        if (!full) depth <= depth + DP_ONE;
      end else if (pop) begin
        sp <= sp_dec;
        if (!empty) depth <= depth - DP_ONE;
      end
      // An error raised on this edge beats a simultaneous clear.
      overflow  <= (push && full)  || (overflow  && !clear_err);
      underflow <= (pop  && empty) || (underflow && !clear_err);
    end
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with next-PC selection and an integrated call/return stack.
// State advances only on clock edges qualified by the advance phase strobe.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int              PC_W         = PC_W_DEF,
  parameter int              TGT_W        = TGT_W_DEF,
  parameter int              DEPTH        = DEPTH_DEF,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     advance,
  input  logic [2:0]               op,
  input  logic [TGT_W-1:0]         target,
  input  logic [PC_W-TGT_W-1:0]    page_hi,
  input  logic                     skip_cond,
  input  logic                     clear_err,
  output logic [PC_W-1:0]          pc,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
  localparam logic [PC_W-1:0] PC_TWO = PC_W'(2);

  pc_op_t                    op_e;
  logic                      push;
  logic                      pop;
  logic [PC_W-1:0]           pc_inc;
  logic [PC_W-1:0]           pc_next;
  logic [PC_W-1:0]           ret_addr;
  logic [$clog2(DEPTH)-1:0]  sp;

  assign op_e   = pc_op_t'(op);
  assign push   = advance && (op_e == PC_CALL);
  assign pop    = advance && (op_e == PC_RET);
  assign pc_inc = pc + PC_ONE;

  // Unused encodings fall through to the default increment.
  always_comb begin
    pc_next = pc_inc;
    case (op_e)
      PC_SKIP: pc_next = pc + (skip_cond ? PC_TWO : PC_ONE);
      PC_GOTO: pc_next = {page_hi, target};
      PC_CALL: pc_next = {page_hi, target};
      PC_RET:  pc_next = ret_addr;
      PC_HOLD: pc_next = pc;
      default: pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)       pc <= RESET_VECTOR;
    else if (advance) pc <= pc_next;
  end

  ret_stack #(
    .W     (PC_W),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clear_err (clear_err),
    .wdata     (pc_inc),
    .rdata     (ret_addr),
    .sp        (sp),
    .depth     (depth),
    .full      (stack_full),
    .empty     (stack_empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

endmodule

// File: tb/tb_pc_call_stack.sv
// Bench for pc_call_stack: directed vector table followed by random traffic
// checked against an array-based model of the call stack.
module tb_pc_call_stack;
  import pc_pkg::*;

  localparam int PC_W  = 13;
  localparam int TGT_W = 11;
  localparam int DEPTH = 8;

  logic              clk;
  logic              reset;
  logic              advance;
  logic [2:0]        op;
  logic [TGT_W-1:0]  target;
  logic [1:0]        page_hi;
  logic              skip_cond;
  logic              clear_err;
  logic [PC_W-1:0]   pc;
  logic [3:0]        depth;
  logic              stack_full;
  logic              stack_empty;
  logic              overflow;
  logic              underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [PC_W-1:0] m_mem [DEPTH];
  logic [PC_W-1:0] m_pc;
  int              m_sp;
  int              m_depth;
  logic            m_ovf;
  logic            m_unf;

  typedef struct {
    logic             rst_n;
    logic             adv;
    logic [2:0]       op;
    logic [TGT_W-1:0] tgt;
    logic [1:0]       pg;
    logic             sc;
    logic             ce;
    logic [PC_W-1:0]  e_pc;
    int               e_depth;
    logic             e_ovf;
    logic             e_unf;
  } vec_t;

  vec_t vecs[$];

  pc_call_stack #(
    .PC_W         (PC_W),
    .TGT_W        (TGT_W),
    .DEPTH        (DEPTH),
    .RESET_VECTOR ('0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .advance     (advance),
    .op          (op),
    .target      (target),
    .page_hi     (page_hi),
    .skip_cond   (skip_cond),
    .clear_err   (clear_err),
    .pc          (pc),
    .depth       (depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Clock and initial input levels
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic a, input logic [2:0] o,
                              input int t, input int p, input logic s, input logic c,
                              input int epc, input int edep, input logic eo, input logic eu);
    vec_t v;
    v.rst_n = r; v.adv = a; v.op = o; v.tgt = TGT_W'(t); v.pg = 2'(p);
    v.sc = s; v.ce = c; v.e_pc = PC_W'(epc); v.e_depth = edep;
    v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  // Model: stack as an indexed array with a modular pointer and a bounded count.
  task automatic model_update(input logic r, input logic a, input logic [2:0] o,
                              input logic [TGT_W-1:0] t, input logic [1:0] p,
                              input logic s, input logic c);
    int tgt_full;
    logic push_err, pop_err;
    tgt_full = int'(p) * (1 << TGT_W) + int'(t);
    push_err = 1'b0;
    pop_err  = 1'b0;
    if (!r) begin
      m_pc = '0; m_sp = 0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
      return;
    end
    if (a) begin
      case (o)
        3'd1: m_pc = PC_W'((int'(m_pc) + (s ? 2 : 1)) % (1 << PC_W));
        3'd2: m_pc = PC_W'(tgt_full);
        3'd3: begin
          m_mem[m_sp] = PC_W'((int'(m_pc) + 1) % (1 << PC_W));
          m_sp = (m_sp + 1) % DEPTH;
          if (m_depth == DEPTH) push_err = 1'b1;
          else m_depth++;
          m_pc = PC_W'(tgt_full);
        end
        3'd4: begin
          m_sp = (m_sp + DEPTH - 1) % DEPTH;
          m_pc = m_mem[m_sp];
          if (m_depth == 0) pop_err = 1'b1;
          else m_depth--;
        end
        3'd5: m_pc = m_pc;
        default: m_pc = PC_W'((int'(m_pc) + 1) % (1 << PC_W));
      endcase
    end
    m_ovf = push_err || (m_ovf && !c);
    m_unf = pop_err  || (m_unf && !c);
  endtask

  // Driver: set inputs away from the edge, let one edge pass, sample 1 ns later.
  task automatic drive(input logic r, input logic a, input logic [2:0] o,
                       input logic [TGT_W-1:0] t, input logic [1:0] p,
                       input logic s, input logic c);
    reset = r; advance = a; op = o; target = t; page_hi = p;
    skip_cond = s; clear_err = c;
    @(posedge clk);
    model_update(r, a, o, t, p, s, c);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int epc, input int edep,
                         input logic eo, input logic eu);
    chk({tag, " pc"}, int'(pc), epc);
    chk({tag, " depth"}, int'(depth), edep);
    chk({tag, " full"}, int'(stack_full), int'(edep == DEPTH));
    chk({tag, " empty"}, int'(stack_empty), int'(edep == 0));
    chk({tag, " overflow"}, int'(overflow), int'(eo));
    chk({tag, " underflow"}, int'(underflow), int'(eu));
  endtask

  initial begin
    reset = 1'b0; advance = 1'b0; op = 3'd0; target = '0; page_hi = '0;
    skip_cond = 1'b0; clear_err = 1'b0;

    // Reset, INC with idle edges interleaved, CALL/RETURN round trip
    vecs.push_back(mk(0, 1, PC_INC,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, PC_INC,  0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, PC_INC,  0, 0, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(1, 0, PC_INC,  0, 0, 0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(1, 1, PC_INC,  0, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0, PC_GOTO, 9, 1, 0, 0, 3, 0, 0, 0));
    vecs.push_back(mk(1, 1, PC_INC,  0, 0, 0, 0, 4, 0, 0, 0));
    vecs.push_back(mk(1, 1, PC_INC,  0, 0, 0, 0, 5, 0, 0, 0));
    vecs.push_back(mk(1, 1, PC_GOTO, 'h010, 0, 0, 0, 'h010, 0, 0, 0));
    vecs.push_back(mk(1, 1, PC_CALL, 'h123, 1, 0, 0, 'h923, 1, 0, 0));
    vecs.push_back(mk(1, 1, PC_RET,  0, 0, 0, 0, 'h011, 0, 0, 0));
    // Nine nested calls overflow an 8-deep stack; returns unwind 9..2 then underflow
    vecs.push_back(mk(0, 1, PC_INC,  0, 0, 0, 0, 0, 0, 0, 0));
    for (int n = 1; n <= 9; n++)
      vecs.push_back(mk(1, 1, PC_CALL, n, 0, 0, 0, n, (n > DEPTH) ? DEPTH : n, n == 9, 0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1, 1, PC_RET, 0, 0, 0, 0, 10 - k, 8 - k, 1, 0));
    vecs.push_back(mk(1, 1, PC_RET,  0, 0, 0, 0, 9, 0, 1, 1));
    vecs.push_back(mk(1, 0, PC_INC,  0, 0, 0, 1, 9, 0, 0, 0));
    // Underflow after reset, clear alone, clear against a fresh underflow
    vecs.push_back(mk(0, 1, PC_INC,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, PC_RET,  0, 0, 0, 0, 8, 0, 0, 1));
    vecs.push_back(mk(1, 0, PC_INC,  0, 0, 0, 1, 8, 0, 0, 0));
    vecs.push_back(mk(1, 1, PC_RET,  0, 0, 0, 1, 7, 0, 0, 1));
    vecs.push_back(mk(1, 0, PC_INC,  0, 0, 0, 1, 7, 0, 0, 0));
    // Wrap and skip arithmetic
    vecs.push_back(mk(1, 1, PC_GOTO, 'h7FE, 3, 0, 0, 'h1FFE, 0, 0, 0));
    vecs.push_back(mk(1, 1, PC_GOTO, 'h7FF, 3, 0, 0, 'h1FFF, 0, 0, 0));
    vecs.push_back(mk(1, 1, PC_SKIP, 0, 0, 1, 0, 'h0001, 0, 0, 0));
    vecs.push_back(mk(1, 1, PC_GOTO, 5, 0, 0, 0, 5, 0, 0, 0));
    vecs.push_back(mk(1, 1, PC_SKIP, 0, 0, 0, 0, 6, 0, 0, 0));
    vecs.push_back(mk(1, 1, PC_SKIP, 0, 0, 1, 0, 8, 0, 0, 0));
    // Reset on the same edge as a CALL at depth 3, then HOLD and spare encodings
    vecs.push_back(mk(1, 1, PC_CALL, 'h20, 0, 0, 0, 'h20, 1, 0, 0));
    vecs.push_back(mk(1, 1, PC_CALL, 'h30, 0, 0, 0, 'h30, 2, 0, 0));
    vecs.push_back(mk(1, 1, PC_CALL, 'h40, 0, 0, 0, 'h40, 3, 0, 0));
    vecs.push_back(mk(0, 1, PC_CALL, 'h50, 0, 0, 0, 0, 0, 0, 0));
    for (int h = 0; h < 4; h++)
      vecs.push_back(mk(1, 1, PC_HOLD, 'h55, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3'b110, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3'b111, 0, 0, 0, 0, 2, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].adv, vecs[i].op, vecs[i].tgt, vecs[i].pg,
            vecs[i].sc, vecs[i].ce);
      chk_all($sformatf("vec%0d", i), int'(vecs[i].e_pc), vecs[i].e_depth,
              vecs[i].e_ovf, vecs[i].e_unf);
    end

    // Overflow set on the same edge as clear_err stays set
    for (int n = 0; n < DEPTH; n++) drive(1, 1, PC_CALL, TGT_W'(n), 0, 0, 0);
    drive(1, 1, PC_CALL, 'h77, 2, 0, 1);
    chk_all("ovf_vs_clear", 'h1077, DEPTH, 1, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic r, a, s, c;
      logic [2:0] o;
      r = ($urandom_range(0, 40) != 0);
      a = ($urandom_range(0, 3) != 0);
      o = 3'($urandom_range(0, 7));
      s = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 9) == 0);
      drive(r, a, o, TGT_W'($urandom), 2'($urandom), s, c);
      chk_all($sformatf("rnd%0d", i), int'(m_pc), m_depth, m_ovf, m_unf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- Parametrised program-counter unit with an integrated hardware call/return stack.
- Successor to the fixed 13-bit counter used by the fetch path.
- Adds generic PC and stack widths, skip-on-condition, page-high-bit injection, stack depth reporting, and sticky overflow/underflow error flags.
- Updates only on the phase strobe from the four-phase clock scheme, so it drops into the existing fetch/decode/ALU/save sequence.

Parameters:
PC_W, 13, program counter width in bits
TGT_W, 11, width of the jump/call target field from the decoder (TGT_W <= PC_W)
DEPTH, 8, number of return-address entries (power of two, >= 2)
RESET_VECTOR, 0, PC value loaded on reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
advance  in  1  phase strobe; state updates only on a clk rising edge with advance=1
op  in  3  pc_op_t operation from the decoder
target  in  TGT_W  GOTO/CALL target (instruction literal field)
page_hi  in  PC_W-TGT_W  upper PC bits for GOTO/CALL targets
skip_cond  in  1  skip qualifier from ALU zero/flag logic
clear_err  in  1  clears sticky error flags
pc  out  PC_W  current program counter
depth  out  $clog2(DEPTH)+1  number of valid stack entries
stack_full  out  1  depth == DEPTH
stack_empty  out  1  depth == 0
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset: reset=0 at a rising edge forces pc=RESET_VECTOR, depth=0, internal stack pointer sp=0, overflow=0, underflow=0. Reset overrides advance and every other input. Stack RAM contents are not cleared.
- No state changes when advance=0, except clear_err, which acts on any edge.
- Ops, evaluated at an edge with advance=1; all PC arithmetic is modulo 2^PC_W:
  - INC (000): pc <= pc+1.
  - SKIP (001): pc <= pc+2 if skip_cond=1, else pc+1.
  - GOTO (010): pc <= {page_hi, target}.
  - CALL (011): push pc+1, then pc <= {page_hi, target}.
  - RETURN (100): pop; pc <= popped value.
  - HOLD (101): pc unchanged (stall).
  - 110 and 111: treated as INC.
- Latency: one edge. pc, depth and flags change together on the same edge; outputs are registered and there is no combinational path from inputs to outputs.
- Stack is a circular buffer:
  - Push writes entry[sp] then sp <= sp+1 mod DEPTH.
  - Pop reads entry[sp-1 mod DEPTH] then sp <= sp-1 mod DEPTH.
- Push while full: the oldest entry is overwritten (circular). depth stays DEPTH, overflow <= 1.
- Pop while empty: pc still loads entry[sp-1] (stale wrap value). sp decrements, depth stays 0, underflow <= 1.
- Flag priority on the same edge: a set caused by an op wins over clear_err.
- stack_full and stack_empty are decoded from the registered depth.
- Reset mid-CALL: reset wins. No push occurs and pc=RESET_VECTOR.

Decomposition:
- Shared package pc_pkg holds:
  - typedef enum logic[2:0] pc_op_t (PC_INC, PC_SKIP, PC_GOTO, PC_CALL, PC_RET, PC_HOLD).
  - The default constants PC_W_DEF=13, TGT_W_DEF=11, DEPTH_DEF=8.
- The decoder imports the same enum.
- One sub-module, ret_stack: circular LIFO with push/pop/wdata/rdata, sp, depth and the full/empty/overflow/underflow logic.
- The top level holds the PC register and next-PC mux.

Test Plan:
- Reset then 5 INC strobes with advance=1 -> pc 0,1,2,3,4,5. Interleaved edges with advance=0 leave pc unchanged.
- pc=0x0010, CALL target=0x123 page_hi=2'b01 -> pc=0x0923, depth=1. Then RETURN -> pc=0x0011, depth=0, no flags.
- 9 nested CALLs from pc=0,1,...(each target=n) with DEPTH=8 -> depth=8, stack_full=1, overflow=1 after the 9th. 8 RETURNs then yield the return addresses of CALLs 9..2; the 9th RETURN sets underflow=1.
- RETURN on an empty stack after reset -> underflow=1, depth=0. clear_err=1 alone -> underflow=0. clear_err together with an underflowing RETURN -> underflow stays 1.
- SKIP at pc=0x1FFF with skip_cond=1 -> pc=0x0001 (wrap). SKIP with skip_cond=0 at pc=0x0005 -> 0x0006. GOTO from pc=0x1FFE to {2'b11,11'h7FF} -> 0x1FFF.
- reset=0 asserted on the same edge as CALL with depth=3 -> pc=RESET_VECTOR, depth=0, flags 0. HOLD -> pc constant over 4 strobes.
